// File: rtl/joy_db15_tx.sv
// DB15 joystick adapter serializer: snapshots two player words on load, shifts on joy_clk.
// Optional watchdog abandons a stalled shift when JOY_DB15_TX_TIMEOUT_EN is defined.
module joy_db15_tx #(
  parameter int BITS_PER_PLAYER = 12,
  parameter int SYNC_STAGES     = 2,
  parameter int TIMEOUT_CYCLES  = 65535
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] joystick1,
  input  logic [15:0] joystick2,
  input  logic        joy_load,
  input  logic        joy_clk,
  output logic        joy_data,
  output logic        busy,
  output logic        frame_done,
  output logic [5:0]  bit_count
);

  localparam int FRAME_BITS = 2 * BITS_PER_PLAYER;
  localparam logic [5:0] FB = 6'(FRAME_BITS);

  typedef enum logic [1:0] {
    IDLE,
    LOADED,
    SHIFT
  } state_t;

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] load_ff;
  logic [SYNC_STAGES-1:0] clk_ff;
  logic                   clk_q;
  logic                   load_s;
  logic                   clk_s;
  logic                   rise;
  logic                   timeout;
  logic                   last;
  logic                   shift_en;
  logic [FRAME_BITS-1:0]  sreg;
  logic [FRAME_BITS-1:0]  ld_word;
  logic                   unused_cfg;

  assign unused_cfg = ^{joystick1, joystick2, TIMEOUT_CYCLES == 0};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_ff <= '1;
      clk_ff  <= '1;
      clk_q   <= 1'b1;
    end else begin
      load_ff <= {load_ff[SYNC_STAGES-2:0], joy_load};
      clk_ff  <= {clk_ff[SYNC_STAGES-2:0], joy_clk};
      clk_q   <= clk_s;
    end
  end

  assign load_s  = load_ff[SYNC_STAGES-1];
  assign clk_s   = clk_ff[SYNC_STAGES-1];
  assign rise    = clk_s & ~clk_q;
  assign ld_word = ~{joystick2[BITS_PER_PLAYER-1:0],
                     joystick1[BITS_PER_PLAYER-1:0]};

`ifdef JOY_DB15_TX_TIMEOUT_EN
  logic [15:0] wdog;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog <= '0;
    end else if (state != SHIFT || rise) begin
      wdog <= '0;
    end else if (wdog != 16'hffff) begin
      wdog <= wdog + 16'd1;
    end
  end

  assign timeout = (state == SHIFT) && !rise &&
                   (wdog >= 16'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (!load_s) state_nx = LOADED;
      LOADED: if (load_s)  state_nx = SHIFT;
      SHIFT: begin
        if (!load_s)               state_nx = LOADED;
        else if (shift_en && last) state_nx = IDLE;
        else if (timeout)          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    last     = (bit_count == FB - 6'd1);
    shift_en = (state == SHIFT) && load_s && rise &&
               (bit_count != FB);
  end

  // Load takes priority over a coincident shift edge in every state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sreg       <= '1;
      bit_count  <= '0;
      frame_done <= 1'b0;
      joy_data   <= 1'b1;
    end else begin
      frame_done <= shift_en && last;
      joy_data   <= (state == IDLE) ? 1'b1 : sreg[0];
      if (!load_s) begin
        sreg      <= ld_word;
        bit_count <= '0;
      end else if (shift_en) begin
        sreg      <= {1'b1, sreg[FRAME_BITS-1:1]};
        bit_count <= bit_count + 6'd1;
      end else if (timeout) begin
        sreg      <= '1;
        bit_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_joy_db15_tx.sv
// Directed bench for joy_db15_tx: frame order, reload, load/clk collision, overrun, stall.
// Stall expectations follow JOY_DB15_TX_TIMEOUT_EN.
module tb_joy_db15_tx;

  logic        clk;
  logic        reset_n;
  logic [15:0] joystick1;
  logic [15:0] joystick2;
  logic        joy_load;
  logic        joy_clk;
  logic        joy_data;
  logic        busy;
  logic        frame_done;
  logic [5:0]  bit_count;

  int errors = 0;
  int checks = 0;
  int fd_count = 0;
  int fd_base;
  int busy_drops;

  joy_db15_tx #(
    .BITS_PER_PLAYER(12),
    .SYNC_STAGES(2),
    .TIMEOUT_CYCLES(200)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .joystick1(joystick1),
    .joystick2(joystick2),
    .joy_load(joy_load),
    .joy_clk(joy_clk),
    .joy_data(joy_data),
    .busy(busy),
    .frame_done(frame_done),
    .bit_count(bit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset_n && frame_done === 1'b1) fd_count++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input int idx,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h",
             tag, idx, obs, exp);
    end
  endtask

  task automatic load_pulse();
    joy_load = 1'b0;
    wait_cyc(20);
    joy_load = 1'b1;
    wait_cyc(10);
  endtask

  task automatic clk_pulse(input string tag, input int idx,
                           input logic exp);
    joy_clk = 1'b0;
    wait_cyc(20);
    chk(tag, idx, 32'(joy_data), 32'(exp));
    joy_clk = 1'b1;
    wait_cyc(20);
    joy_clk = 1'b0;
  endtask

  function automatic logic exp_bit(input logic [15:0] j1,
                                   input logic [15:0] j2,
                                   input int i);
    if (i < 12)      return ~j1[i];
    else if (i < 24) return ~j2[i-12];
    else             return 1'b1;
  endfunction

  logic [23:0] frame2;

  initial begin
    reset_n   = 1'b0;
    joystick1 = 16'h0000;
    joystick2 = 16'h0000;
    joy_load  = 1'b1;
    joy_clk   = 1'b0;
    frame2    = 24'b0111_1111_1101_1111_1110_1110;
    wait_cyc(5);
    chk("rst_data", 0, 32'(joy_data), 32'd1);
    chk("rst_busy", 0, 32'(busy), 32'd0);
    chk("rst_cnt", 0, 32'(bit_count), 32'd0);
    chk("rst_fd", 0, 32'(frame_done), 32'd0);
    reset_n = 1'b1;
    wait_cyc(100);
    chk("idle_data", 0, 32'(joy_data), 32'd1);
    chk("idle_busy", 0, 32'(busy), 32'd0);
    chk("idle_cnt", 0, 32'(bit_count), 32'd0);
    chk("idle_fd", 0, fd_count, 32'd0);

    // full frame
    joystick1 = 16'h0011;
    joystick2 = 16'h0802;
    fd_base = fd_count;
    load_pulse();
    chk("ld_busy", 0, 32'(busy), 32'd1);
    chk("ld_cnt", 0, 32'(bit_count), 32'd0);
    for (int i = 0; i < 24; i++) begin
      clk_pulse("frame", i, frame2[i]);
    end
    wait_cyc(10);
    chk("frm_fd", 0, fd_count - fd_base, 32'd1);
    chk("frm_cnt", 0, 32'(bit_count), 32'd24);
    chk("frm_busy", 0, 32'(busy), 32'd0);
    chk("frm_data", 0, 32'(joy_data), 32'd1);

    // mid-frame reload
    fd_base = fd_count;
    load_pulse();
    for (int i = 0; i < 5; i++) begin
      clk_pulse("mid", i, frame2[i]);
    end
    wait_cyc(10);
    chk("mid_cnt5", 0, 32'(bit_count), 32'd5);
    joystick1 = 16'h0001;
    load_pulse();
    chk("rl_cnt", 0, 32'(bit_count), 32'd0);
    chk("rl_busy", 0, 32'(busy), 32'd1);
    chk("rl_fd", 0, fd_count - fd_base, 32'd0);
    for (int i = 0; i < 5; i++) begin
      clk_pulse("rl", i, exp_bit(joystick1, joystick2, i));
    end

    // load and clk edges together: load wins
    fd_base = fd_count;
    for (int i = 5; i < 8; i++) begin
      clk_pulse("pre", i, exp_bit(joystick1, joystick2, i));
    end
    joy_load = 1'b0;
    joy_clk  = 1'b1;
    wait_cyc(10);
    joy_clk  = 1'b0;
    wait_cyc(10);
    joy_load = 1'b1;
    wait_cyc(10);
    chk("col_cnt", 0, 32'(bit_count), 32'd0);
    chk("col_data", 0, 32'(joy_data), 32'd0);
    chk("col_fd", 0, fd_count - fd_base, 32'd0);

    // 30 pulses: overrun bits read 1
    for (int i = 0; i < 30; i++) begin
      clk_pulse("ovr", i, exp_bit(joystick1, joystick2, i));
    end
    wait_cyc(10);
    chk("ovr_fd", 0, fd_count - fd_base, 32'd1);
    chk("ovr_cnt", 0, 32'(bit_count), 32'd24);

    // stall after 3 bits
    fd_base = fd_count;
    busy_drops = 0;
    load_pulse();
    for (int i = 0; i < 3; i++) begin
      clk_pulse("stl", i, exp_bit(joystick1, joystick2, i));
    end
    for (int c = 0; c < 250; c++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_drops++;
    end
`ifdef JOY_DB15_TX_TIMEOUT_EN
    chk("to_busy", 0, 32'(busy), 32'd0);
    chk("to_cnt", 0, 32'(bit_count), 32'd0);
    chk("to_data", 0, 32'(joy_data), 32'd1);
    chk("to_drop", 0, 32'(busy_drops > 0), 32'd1);
`else
    chk("stl_busy", 0, busy_drops, 32'd0);
    chk("stl_cnt", 0, 32'(bit_count), 32'd3);
    chk("stl_data", 0, 32'(joy_data),
        32'(exp_bit(joystick1, joystick2, 3)));
`endif
    chk("stl_fd", 0, fd_count - fd_base, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
